// File: rtl/lsu_pkg.sv
// Shared constants and state encoding for the load/store initiator.
package lsu_pkg;

    localparam int unsigned DATA_W = 32;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        RMW_RD = 3'd2,
        WRITE  = 3'd3,
        RESP   = 3'd4
    } lsu_state_t;

endpackage

// File: rtl/lsu_lane_align.sv
// Byte/half lane handling: load extract with sign/zero extension and store merge
// into a read word. Shared by the LOAD and RMW_RD paths.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [2:0]        i_Funct3,
    input  logic [1:0]        i_Lane,
    input  logic [DATA_W-1:0] i_Rd,
    input  logic [15:0]       i_WData,
    output logic [DATA_W-1:0] o_Load_c,
    output logic [DATA_W-1:0] o_Merge_c
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic        w_sext;

    assign w_byte = i_Rd[{i_Lane, 3'b000} +: 8];
    assign w_half = i_Lane[1] ? i_Rd[31:16] : i_Rd[15:0];
    assign w_sext = ~i_Funct3[2];

    always_comb begin
        o_Load_c  = i_Rd;
        o_Merge_c = i_Rd;
        case (i_Funct3[1:0])
            F3_B[1:0]: begin
                o_Load_c = {{24{w_byte[7] & w_sext}}, w_byte};
                o_Merge_c[{i_Lane, 3'b000} +: 8] = i_WData[7:0];
            end
            F3_H[1:0]: begin
                o_Load_c = {{16{w_half[15] & w_sext}}, w_half};
                o_Merge_c[{i_Lane[1], 4'b0000} +: 16] = i_WData;
            end
            default: begin
                o_Load_c  = i_Rd;
                o_Merge_c = i_Rd;
            end
        endcase
    end

endmodule

// File: rtl/lsu_mem_initiator.sv
// Load/store initiator between core datapath and word-addressed data memory.
// Optional macro LSU_MISALIGN_TRAP_EN: misaligned H/W requests error instead of force-aligning.
module lsu_mem_initiator
    import lsu_pkg::*;
#(
    parameter int unsigned ADDR_W = 10
) (
    input  logic              i_CLK,
    input  logic              i_Reset,
    input  logic              i_Req_Valid,
    output logic              o_Req_Ready,
    input  logic              i_Req_Write,
    input  logic [2:0]        i_Req_Funct3,
    input  logic [ADDR_W-1:0] i_Req_Addr,
    input  logic [DATA_W-1:0] i_Req_WData,
    output logic              o_Rsp_Valid,
    output logic [DATA_W-1:0] o_Rsp_RData,
    output logic              o_Rsp_Err,
    output logic [ADDR_W-3:0] o_Mem_A,
    output logic              o_Mem_WE,
    output logic [DATA_W-1:0] o_Mem_WD,
    input  logic [DATA_W-1:0] i_Mem_RD
);

    lsu_state_t        r_state, w_state_nxt;
    logic [2:0]        r_funct3;
    logic              r_write;
    logic [ADDR_W-1:0] r_addr;
    logic [15:0]       r_wdata;
    logic              r_req_ready, r_rsp_valid, r_rsp_err, r_mem_we;
    logic [DATA_W-1:0] r_rsp_rdata, r_mem_wd;

    logic              w_accept, w_invalid, w_misalign, w_req_err, w_rsp_err_nxt;
    logic [ADDR_W-1:0] w_addr_aligned;
    logic [DATA_W-1:0] w_rsp_rdata_nxt, w_mem_wd_nxt, w_load_c, w_merge_c;

    // Request classification on the incoming (not yet latched) request
    assign w_invalid = !(i_Req_Funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU})
                     || (i_Req_Write && i_Req_Funct3[2]);
    assign w_misalign = ((i_Req_Funct3[1:0] == F3_H[1:0]) && i_Req_Addr[0])
                     || ((i_Req_Funct3[1:0] == F3_W[1:0]) && (i_Req_Addr[1:0] != 2'b00));

    always_comb begin
        w_addr_aligned = i_Req_Addr;
        if (w_misalign)
            w_addr_aligned[1:0] = (i_Req_Funct3[1:0] == F3_W[1:0]) ? 2'b00 : {i_Req_Addr[1], 1'b0};
    end

`ifdef LSU_MISALIGN_TRAP_EN
    assign w_req_err = w_invalid || w_misalign;
`else
    assign w_req_err = w_invalid;
`endif

    lsu_lane_align u_lane_align (
        .i_Funct3  (r_funct3),
        .i_Lane    (r_addr[1:0]),
        .i_Rd      (i_Mem_RD),
        .i_WData   (r_wdata),
        .o_Load_c  (w_load_c),
        .o_Merge_c (w_merge_c)
    );

    always_ff @(posedge i_CLK or negedge i_Reset) begin
        if (!i_Reset) r_state <= IDLE;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_accept        = 1'b0;
        w_rsp_err_nxt   = 1'b0;
        w_rsp_rdata_nxt = '0;
        w_mem_wd_nxt    = '0;
        case (r_state)
            IDLE: begin
                if (i_Req_Valid) begin
                    w_accept = 1'b1;
                    if (w_req_err) begin
                        w_state_nxt   = RESP;
                        w_rsp_err_nxt = 1'b1;
                    end else if (!i_Req_Write) begin
                        w_state_nxt = LOAD;
                    end else if (i_Req_Funct3[1:0] == F3_W[1:0]) begin
                        w_state_nxt  = WRITE;
                        w_mem_wd_nxt = i_Req_WData;
                    end else begin
                        w_state_nxt = RMW_RD;
                    end
                end
            end
            LOAD: begin
                w_state_nxt     = RESP;
                w_rsp_rdata_nxt = r_write ? '0 : w_load_c;
            end
            RMW_RD: begin
                w_state_nxt  = WRITE;
                w_mem_wd_nxt = w_merge_c;
            end
            WRITE:   w_state_nxt = RESP;
            RESP:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Registered outputs follow the next state so they line up with it
    always_ff @(posedge i_CLK or negedge i_Reset) begin
        if (!i_Reset) begin
            r_req_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= '0;
            r_mem_we    <= 1'b0;
            r_mem_wd    <= '0;
        end else begin
            r_req_ready <= (w_state_nxt == IDLE);
            r_rsp_valid <= (w_state_nxt == RESP);
            r_rsp_err   <= w_rsp_err_nxt;
            r_rsp_rdata <= w_rsp_rdata_nxt;
            r_mem_we    <= (w_state_nxt == WRITE);
            r_mem_wd    <= w_mem_wd_nxt;
        end
    end

    always_ff @(posedge i_CLK or negedge i_Reset) begin
        if (!i_Reset) begin
            r_funct3 <= '0;
            r_write  <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
        end else if (w_accept) begin
            r_funct3 <= i_Req_Funct3;
            r_write  <= i_Req_Write;
            r_addr   <= w_addr_aligned;
            r_wdata  <= i_Req_WData[15:0];
        end
    end

    assign o_Req_Ready = r_req_ready;
    assign o_Rsp_Valid = r_rsp_valid;
    assign o_Rsp_RData = r_rsp_rdata;
    assign o_Rsp_Err   = r_rsp_err;
    assign o_Mem_A     = r_addr[ADDR_W-1:2];
    assign o_Mem_WE    = r_mem_we;
    assign o_Mem_WD    = r_mem_wd;

endmodule

// File: tb/tb_lsu_mem_initiator.sv
// Self-checking bench for lsu_mem_initiator: directed spec vectors plus random
// requests compared against a byte-level behavioural memory model.
`timescale 1ns/1ps
module tb_lsu_mem_initiator;

    localparam int unsigned ADDR_W = 10;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_write;
    logic [2:0]  req_f3;
    logic [9:0]  req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;
    logic [7:0]  mem_a;
    logic        mem_we;
    logic [31:0] mem_wd, mem_rd;

    logic [31:0] mem     [256];
    logic [31:0] ref_mem [256];
    logic        load_req;
    int          we_cnt = 0, rsp_cnt = 0;
    logic [7:0]  we_a;
    logic [31:0] we_wd;
    int          checks = 0, failures = 0;

    always #5 clk = ~clk;

    lsu_mem_initiator #(.ADDR_W(ADDR_W)) dut (
        .i_CLK        (clk),
        .i_Reset      (rst_n),
        .i_Req_Valid  (req_valid),
        .o_Req_Ready  (req_ready),
        .i_Req_Write  (req_write),
        .i_Req_Funct3 (req_f3),
        .i_Req_Addr   (req_addr),
        .i_Req_WData  (req_wdata),
        .o_Rsp_Valid  (rsp_valid),
        .o_Rsp_RData  (rsp_rdata),
        .o_Rsp_Err    (rsp_err),
        .o_Mem_A      (mem_a),
        .o_Mem_WE     (mem_we),
        .o_Mem_WD     (mem_wd),
        .i_Mem_RD     (mem_rd)
    );

    assign mem_rd = mem[mem_a];

    // Environment memory: preload from the model copy, or take DUT writes
    always @(posedge clk) begin
        if (load_req) begin
            for (int i = 0; i < 256; i++) mem[i] <= ref_mem[i];
        end else if (mem_we) begin
            mem[mem_a] <= mem_wd;
            we_cnt     <= we_cnt + 1;
            we_a       <= mem_a;
            we_wd      <= mem_wd;
        end
        if (rsp_valid) rsp_cnt <= rsp_cnt + 1;
    end

    task automatic sync_mem();
        @(posedge clk); #1 load_req = 1'b1;
        @(posedge clk); #1 load_req = 1'b0;
    endtask

    // Drive one request and observe response, latency, write pulses
    task automatic run_txn(input logic wr, input logic [2:0] f3, input logic [9:0] addr,
                           input logic [31:0] wd, output logic [31:0] o_rd, output logic o_err,
                           output int o_lat, output int o_we, output logic o_one_shot);
        int we0;
        we0 = we_cnt;
        @(posedge clk); #1;
        req_valid = 1'b1; req_write = wr; req_f3 = f3; req_addr = addr; req_wdata = wd;
        @(posedge clk); #1;
        req_valid = 1'b0;
        o_lat = 1;
        while (!rsp_valid && o_lat < 8) begin
            @(posedge clk); #1;
            o_lat++;
        end
        o_rd  = rsp_rdata;
        o_err = rsp_err;
        @(posedge clk); #1;
        o_one_shot = !rsp_valid && req_ready;
        o_we = we_cnt - we0;
    endtask

    // Reference: byte-addressed semantics computed from access size and offset
    task automatic model(input logic wr, input logic [2:0] f3, input logic [9:0] addr,
                         input logic [31:0] wd, output logic [31:0] e_rd, output logic e_err,
                         output int e_lat, output int e_we, output logic [7:0] e_a,
                         output logic [31:0] e_wd);
        int a, size, off, widx;
        logic [31:0] word, mask, val;
        e_rd = 0; e_err = 0; e_we = 0; e_a = 0; e_wd = 0; e_lat = 1;
        if (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111 || (wr && f3[2])) begin
            e_err = 1; return;
        end
        size = 1 << f3[1:0];
        a = int'(addr);
`ifdef LSU_MISALIGN_TRAP_EN
        if (a % size != 0) begin e_err = 1; return; end
`else
        a = a - (a % size);
`endif
        widx = a / 4; off = a % 4;
        word = ref_mem[widx];
        if (!wr) begin
            e_lat = 2;
            val = word >> (8 * off);
            mask = (size == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * size)) - 32'd1);
            val = val & mask;
            if (!f3[2] && size < 4 && val[8*size-1]) val = val | ~mask;
            e_rd = val;
        end else begin
            e_lat = (size == 4) ? 2 : 3;
            for (int k = 0; k < size; k++) word[8*(off+k) +: 8] = wd[8*k +: 8];
            ref_mem[widx] = word;
            e_we = 1; e_a = 8'(widx); e_wd = word;
        end
    endtask

    task automatic test_reset();
        checks++; if (req_ready !== 1'b1)   begin failures++; $display("FAIL reset_ready got=%b exp=1", req_ready); end
        checks++; if (rsp_valid !== 1'b0)   begin failures++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
        checks++; if (rsp_rdata !== 32'h0)  begin failures++; $display("FAIL reset_rdata got=%h exp=0", rsp_rdata); end
        checks++; if (rsp_err !== 1'b0)     begin failures++; $display("FAIL reset_err got=%b exp=0", rsp_err); end
        checks++; if (mem_a !== 8'h0)       begin failures++; $display("FAIL reset_mem_a got=%h exp=0", mem_a); end
        checks++; if (mem_we !== 1'b0)      begin failures++; $display("FAIL reset_we got=%b exp=0", mem_we); end
        checks++; if (mem_wd !== 32'h0)     begin failures++; $display("FAIL reset_wd got=%h exp=0", mem_wd); end
    endtask

    task automatic test_loads();
        logic [9:0]  addrs [3] = '{10'h015, 10'h015, 10'h016};
        logic [2:0]  f3s   [3] = '{3'b000, 3'b100, 3'b101};
        logic [31:0] exps  [3] = '{32'hFFFF_FF82, 32'h0000_0082, 32'h0000_8081};
        logic [31:0] rd; logic err, one; int lat, we;
        ref_mem[5] = 32'h8081_8283;
        sync_mem();
        for (int i = 0; i < 3; i++) begin
            run_txn(1'b0, f3s[i], addrs[i], 32'h0, rd, err, lat, we, one);
            checks++; if (rd !== exps[i]) begin failures++; $display("FAIL load_data[%0d] got=%h exp=%h", i, rd, exps[i]); end
            checks++; if (err !== 1'b0)   begin failures++; $display("FAIL load_err[%0d] got=%b exp=0", i, err); end
            checks++; if (lat !== 2)      begin failures++; $display("FAIL load_lat[%0d] got=%0d exp=2", i, lat); end
            checks++; if (one !== 1'b1)   begin failures++; $display("FAIL load_pulse[%0d] got=%b exp=1", i, one); end
        end
    endtask

    task automatic test_stores();
        logic [31:0] rd; logic err, one; int lat, we;
        ref_mem[4] = 32'h1122_3344;
        sync_mem();
        run_txn(1'b1, 3'b000, 10'h011, 32'h0000_00AB, rd, err, lat, we, one);
        checks++; if (we !== 1)              begin failures++; $display("FAIL sb_we_cycles got=%0d exp=1", we); end
        checks++; if (we_a !== 8'd4)         begin failures++; $display("FAIL sb_mem_a got=%h exp=04", we_a); end
        checks++; if (we_wd !== 32'h1122_AB44) begin failures++; $display("FAIL sb_wd got=%h exp=1122ab44", we_wd); end
        checks++; if (lat !== 3)             begin failures++; $display("FAIL sb_lat got=%0d exp=3", lat); end
        checks++; if (rd !== 32'h0 || err !== 1'b0) begin failures++; $display("FAIL sb_rsp got=%h/%b exp=0/0", rd, err); end
        run_txn(1'b1, 3'b010, 10'h3FC, 32'hDEAD_BEEF, rd, err, lat, we, one);
        checks++; if (we_a !== 8'hFF || we_wd !== 32'hDEAD_BEEF) begin failures++; $display("FAIL sw_write got=%h/%h exp=ff/deadbeef", we_a, we_wd); end
        checks++; if (lat !== 2)             begin failures++; $display("FAIL sw_lat got=%0d exp=2", lat); end
        run_txn(1'b0, 3'b010, 10'h3FC, 32'h0, rd, err, lat, we, one);
        checks++; if (rd !== 32'hDEAD_BEEF)  begin failures++; $display("FAIL lw_readback got=%h exp=deadbeef", rd); end
        ref_mem[4] = 32'h1122_AB44;
        ref_mem[255] = 32'hDEAD_BEEF;
    endtask

    task automatic test_errors();
        logic [31:0] rd; logic err, one; int lat, we;
        logic        wrs [2] = '{1'b0, 1'b1};
        logic [2:0]  f3s [2] = '{3'b011, 3'b100};
        for (int i = 0; i < 2; i++) begin
            run_txn(wrs[i], f3s[i], 10'h011, 32'h0000_00CD, rd, err, lat, we, one);
            checks++; if (err !== 1'b1)  begin failures++; $display("FAIL err_flag[%0d] got=%b exp=1", i, err); end
            checks++; if (lat !== 1)     begin failures++; $display("FAIL err_lat[%0d] got=%0d exp=1", i, lat); end
            checks++; if (we !== 0)      begin failures++; $display("FAIL err_we[%0d] got=%0d exp=0", i, we); end
            checks++; if (rd !== 32'h0)  begin failures++; $display("FAIL err_rdata[%0d] got=%h exp=0", i, rd); end
        end
    endtask

    task automatic test_misalign();
        logic [31:0] rd, e_rd; logic err, one, e_err; int lat, we, e_lat;
        ref_mem[1] = 32'h0BAD_F00D;
        sync_mem();
        run_txn(1'b0, 3'b010, 10'h006, 32'h0, rd, err, lat, we, one);
`ifdef LSU_MISALIGN_TRAP_EN
        e_rd = 32'h0; e_err = 1'b1; e_lat = 1;
`else
        e_rd = 32'h0BAD_F00D; e_err = 1'b0; e_lat = 2;
`endif
        checks++; if (rd !== e_rd)   begin failures++; $display("FAIL misalign_data got=%h exp=%h", rd, e_rd); end
        checks++; if (err !== e_err) begin failures++; $display("FAIL misalign_err got=%b exp=%b", err, e_err); end
        checks++; if (lat !== e_lat) begin failures++; $display("FAIL misalign_lat got=%0d exp=%0d", lat, e_lat); end
    endtask

    task automatic test_random();
        logic [31:0] rd, e_rd, e_wd, wd; logic err, one, e_err, wr; int lat, we, e_lat, e_we;
        logic [7:0] e_a; logic [2:0] f3; logic [9:0] addr;
        for (int i = 0; i < 60; i++) begin
            wr = 1'($urandom); f3 = 3'($urandom_range(0, 7));
            addr = 10'($urandom); wd = $urandom;
            if (i % 5 == 0) addr = {addr[9:2], 2'b00};
            model(wr, f3, addr, wd, e_rd, e_err, e_lat, e_we, e_a, e_wd);
            run_txn(wr, f3, addr, wd, rd, err, lat, we, one);
            checks++; if (rd !== e_rd || err !== e_err) begin failures++; $display("FAIL rnd_rsp[%0d] wr=%b f3=%b a=%h got=%h/%b exp=%h/%b", i, wr, f3, addr, rd, err, e_rd, e_err); end
            checks++; if (lat !== e_lat) begin failures++; $display("FAIL rnd_lat[%0d] got=%0d exp=%0d", i, lat, e_lat); end
            checks++; if (we !== e_we)   begin failures++; $display("FAIL rnd_we[%0d] got=%0d exp=%0d", i, we, e_we); end
            if (e_we == 1) begin
                checks++; if (we_a !== e_a || we_wd !== e_wd) begin failures++; $display("FAIL rnd_write[%0d] got=%h/%h exp=%h/%h", i, we_a, we_wd, e_a, e_wd); end
            end
            checks++; if (one !== 1'b1)  begin failures++; $display("FAIL rnd_pulse[%0d] got=%b exp=1", i, one); end
        end
        begin
            int bad = 0;
            for (int j = 0; j < 256; j++) if (mem[j] !== ref_mem[j]) bad++;
            checks++; if (bad !== 0) begin failures++; $display("FAIL rnd_mem_image got=%0d_bad_words exp=0", bad); end
        end
    endtask

    task automatic test_reset_mid_write();
        int rsp0, n;
        ref_mem[9] = 32'h5566_7788;
        sync_mem();
        rsp0 = rsp_cnt;
        @(posedge clk); #1;
        req_valid = 1'b1; req_write = 1'b1; req_f3 = 3'b000; req_addr = 10'h025; req_wdata = 32'h0000_00EE;
        @(posedge clk); #1;
        req_valid = 1'b0;
        n = 0;
        while (!mem_we && n < 6) begin @(posedge clk); #1; n++; end
        checks++; if (mem_we !== 1'b1) begin failures++; $display("FAIL rst_reach_write got=%b exp=1", mem_we); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL rst_we_async got=%b exp=0", mem_we); end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (rsp_cnt !== rsp0)          begin failures++; $display("FAIL rst_no_rsp got=%0d exp=%0d", rsp_cnt, rsp0); end
        checks++; if (req_ready !== 1'b1)        begin failures++; $display("FAIL rst_ready got=%b exp=1", req_ready); end
        checks++; if (mem[9] !== 32'h5566_7788)  begin failures++; $display("FAIL rst_mem_untouched got=%h exp=55667788", mem[9]); end
    endtask

    initial begin
        rst_n = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_f3 = 3'b000;
        req_addr = '0; req_wdata = '0; load_req = 1'b0;
        for (int i = 0; i < 256; i++) ref_mem[i] = $urandom;
        #2 rst_n = 1'b0;
        sync_mem();
        #1 test_reset();
        rst_n = 1'b1;
        test_loads();
        test_stores();
        test_errors();
        test_misalign();
        test_random();
        test_reset_mid_write();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
